// File: rtl/time_counter_pkg.sv
// Shared types and constants for the BCD time-of-day counter: digit type,
// per-digit limits, FSM states and nibble positions in the 24-bit packing.
package time_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
    localparam bcd_digit_t MIN_TENS_MAX = 4'd5;
    localparam bcd_digit_t UNITS_MAX    = 4'd9;

    typedef enum logic {
        RUN     = 1'b0,
        EXPIRED = 1'b1
    } state_e;

    localparam int NUM_DIGITS = 6;
    localparam int DIGITS_W   = 4 * NUM_DIGITS;

    localparam int S0_LSB = 0;
    localparam int S1_LSB = 4;
    localparam int M0_LSB = 8;
    localparam int M1_LSB = 12;
    localparam int H0_LSB = 16;
    localparam int H1_LSB = 20;

    function automatic bcd_digit_t digit_at(input logic [DIGITS_W-1:0] v, input int lsb);
        return v[lsb +: 4];
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD nibble of the time chain: wraps at i_max when counting up, reloads
// i_max on borrow when counting down, and reports carry/borrow to the next digit.
module bcd_digit_counter
    import time_counter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  bcd_digit_t i_max,
    input  logic       i_inc,
    input  logic       i_dec,
    input  logic       i_cin,
    input  logic       i_clr,
    input  logic       i_load,
    input  bcd_digit_t i_load_val,
    output bcd_digit_t o_digit,
    output logic       o_cout
);

    bcd_digit_t r_digit;
    bcd_digit_t w_next;
    logic       w_at_max;
    logic       w_at_zero;

    assign w_at_max  = (r_digit == i_max);
    assign w_at_zero = (r_digit == 4'd0);

    // i_clr lets the top force the 23->00 hour wrap over normal carry behaviour.
    always_comb begin
        w_next = r_digit;
        if (i_clr) begin
            w_next = 4'd0;
        end else if (i_load) begin
            w_next = i_load_val;
        end else if (i_cin && i_inc) begin
            w_next = w_at_max ? 4'd0 : r_digit + 4'd1;
        end else if (i_cin && i_dec) begin
            w_next = w_at_zero ? i_max : r_digit - 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_digit <= 4'd0;
        end else begin
            r_digit <= w_next;
        end
    end

    assign o_digit = r_digit;
    assign o_cout  = i_cin && ((i_inc && w_at_max) || (i_dec && w_at_zero));

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD time-of-day counter with up/down count, validated preset and a
// countdown-expired state; feeds the seven-segment display path.
module bcd_time_counter
    import time_counter_pkg::*;
#(
    parameter int MAX_HOUR_TENS         = 2,
    parameter int MAX_HOUR_UNITS_AT_TOP = 3
) (
    input  logic                clk_1Hz_risingEdge,
    input  logic                reset,
    input  logic                enable,
    input  logic                count_down,
    input  logic                load,
    input  logic [DIGITS_W-1:0] load_value,
    output logic [DIGITS_W-1:0] digits,
    output logic                rollover,
    output logic                expired,
    output logic                load_error
);

    localparam bcd_digit_t HOUR_TENS_MAX  = bcd_digit_t'(MAX_HOUR_TENS);
    localparam bcd_digit_t HOUR_UNITS_TOP = bcd_digit_t'(MAX_HOUR_UNITS_AT_TOP);

    state_e     r_state;
    state_e     w_state_next;
    logic       r_rollover;
    logic       r_load_error;

    logic       w_load_ok;
    logic       w_load_accept;
    logic       w_is_zero;
    logic       w_is_one;
    logic       w_count_up;
    logic       w_count_down;
    logic       w_hour_wrap;
    logic       w_rollover_next;
    logic [5:0] w_cin;
    logic [5:0] w_cout;
    logic [5:0] w_clr;
    bcd_digit_t w_max   [NUM_DIGITS];
    bcd_digit_t w_digit [NUM_DIGITS];

    function automatic logic load_valid(input logic [DIGITS_W-1:0] v);
        bcd_digit_t h1, h0, m1, m0, s1, s0;
        h1 = digit_at(v, H1_LSB);
        h0 = digit_at(v, H0_LSB);
        m1 = digit_at(v, M1_LSB);
        m0 = digit_at(v, M0_LSB);
        s1 = digit_at(v, S1_LSB);
        s0 = digit_at(v, S0_LSB);
        return (s1 <= SEC_TENS_MAX) && (s0 <= UNITS_MAX) &&
               (m1 <= MIN_TENS_MAX) && (m0 <= UNITS_MAX) &&
               (h0 <= UNITS_MAX)    && (h1 <= HOUR_TENS_MAX) &&
               !((h1 == HOUR_TENS_MAX) && (h0 > HOUR_UNITS_TOP));
    endfunction

    assign w_load_ok     = load_valid(load_value);
    assign w_load_accept = load && w_load_ok;
    assign w_is_zero     = (digits == 24'h000000);
    assign w_is_one      = (digits == 24'h000001);

    // State register
    always_ff @(posedge clk_1Hz_risingEdge) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: any load (valid or not) suppresses counting decisions.
    always_comb begin
        w_state_next = r_state;
        if (load) begin
            if (w_load_ok) begin
                w_state_next = RUN;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (enable && count_down && (w_is_zero || w_is_one)) begin
                        w_state_next = EXPIRED;
                    end
                end
                EXPIRED: begin
                    if (!count_down) begin
                        w_state_next = RUN;
                    end
                end
                default: w_state_next = RUN;
            endcase
        end
    end

    // Output logic: per-cycle count direction for the digit chain.
    always_comb begin
        w_count_up   = 1'b0;
        w_count_down = 1'b0;
        if (!load && (r_state == RUN) && enable) begin
            if (count_down) begin
                w_count_down = !w_is_zero;
            end else begin
                w_count_up = 1'b1;
            end
        end
    end

    assign w_max[0] = UNITS_MAX;
    assign w_max[1] = SEC_TENS_MAX;
    assign w_max[2] = UNITS_MAX;
    assign w_max[3] = MIN_TENS_MAX;
    assign w_max[4] = UNITS_MAX;
    assign w_max[5] = HOUR_TENS_MAX;

    // A carry out of minutes-tens only happens at :59:59, so this is the day wrap.
    assign w_hour_wrap = w_count_up && w_cout[3] &&
                         (w_digit[5] == HOUR_TENS_MAX) && (w_digit[4] == HOUR_UNITS_TOP);

    assign w_cin           = {w_cout[4:0], (w_count_up || w_count_down)};
    assign w_clr           = {w_hour_wrap, w_hour_wrap, 4'b0000};
    assign w_rollover_next = w_hour_wrap || (w_count_up && w_cout[5]);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_counter u_digit (
            .i_clk      (clk_1Hz_risingEdge),
            .i_reset    (reset),
            .i_max      (w_max[g]),
            .i_inc      (w_count_up),
            .i_dec      (w_count_down),
            .i_cin      (w_cin[g]),
            .i_clr      (w_clr[g]),
            .i_load     (w_load_accept),
            .i_load_val (load_value[4*g +: 4]),
            .o_digit    (w_digit[g]),
            .o_cout     (w_cout[g])
        );
        assign digits[4*g +: 4] = w_digit[g];
    end

    always_ff @(posedge clk_1Hz_risingEdge) begin
        if (reset) begin
            r_rollover   <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_rollover   <= w_rollover_next;
            r_load_error <= load && !w_load_ok;
        end
    end

    assign rollover   = r_rollover;
    assign load_error = r_load_error;
    assign expired    = (r_state == EXPIRED);

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter: an elapsed-seconds reference model fills
// a scoreboard each cycle, and outputs are checked one cycle later.
module tb_bcd_time_counter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        count_down;
    logic        load;
    logic [23:0] load_value;
    logic [23:0] digits;
    logic        rollover;
    logic        expired;
    logic        load_error;

    typedef struct packed {
        logic [23:0] d;
        logic        ro;
        logic        ex;
        logic        le;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    m_secs  = 0;
    bit    m_exp   = 1'b0;

    bcd_time_counter #(
        .MAX_HOUR_TENS         (2),
        .MAX_HOUR_UNITS_AT_TOP (3)
    ) dut (
        .clk_1Hz_risingEdge (clk),
        .reset              (reset),
        .enable             (enable),
        .count_down         (count_down),
        .load               (load),
        .load_value         (load_value),
        .digits             (digits),
        .rollover           (rollover),
        .expired            (expired),
        .load_error         (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, sec;
        h   = s / 3600;
        m   = (s / 60) % 60;
        sec = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    function automatic int from_bcd(input logic [23:0] v);
        return int'(v[23:20]) * 36000 + int'(v[19:16]) * 3600 + int'(v[15:12]) * 600 +
               int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [23:0] v);
        int h1, h0, m1, m0, s1, s0;
        h1 = int'(v[23:20]); h0 = int'(v[19:16]);
        m1 = int'(v[15:12]); m0 = int'(v[11:8]);
        s1 = int'(v[7:4]);   s0 = int'(v[3:0]);
        return (h1 <= 2) && (h0 <= 9) && !(h1 == 2 && h0 > 3) &&
               (m1 <= 5) && (m0 <= 9) && (s1 <= 5) && (s0 <= 9);
    endfunction

    task automatic model_step(input logic rst, input logic ld, input logic [23:0] lv,
                              input logic en, input logic cd, output exp_t e);
        e = '0;
        if (rst) begin
            m_secs = 0;
            m_exp  = 1'b0;
        end else if (ld) begin
            if (bcd_ok(lv)) begin
                m_secs = from_bcd(lv);
                m_exp  = 1'b0;
            end else begin
                e.le = 1'b1;
            end
        end else if (m_exp) begin
            if (!cd) m_exp = 1'b0;
        end else if (en) begin
            if (!cd) begin
                if (m_secs == 86399) begin
                    m_secs = 0;
                    e.ro   = 1'b1;
                end else begin
                    m_secs++;
                end
            end else begin
                if (m_secs > 0) m_secs--;
                if (m_secs == 0) m_exp = 1'b1;
            end
        end
        e.d  = to_bcd(m_secs);
        e.ex = m_exp;
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        assert (digits === e.d) else begin
            n_fail++;
            $error("FAIL %s digits: observed %06h expected %06h", t, digits, e.d);
        end
        n_tests++;
        assert (rollover === e.ro) else begin
            n_fail++;
            $error("FAIL %s rollover: observed %b expected %b", t, rollover, e.ro);
        end
        n_tests++;
        assert (expired === e.ex) else begin
            n_fail++;
            $error("FAIL %s expired: observed %b expected %b", t, expired, e.ex);
        end
        n_tests++;
        assert (load_error === e.le) else begin
            n_fail++;
            $error("FAIL %s load_error: observed %b expected %b", t, load_error, e.le);
        end
    endtask

    task automatic step(input logic rst, input logic ld, input logic [23:0] lv,
                        input logic en, input logic cd, input string tag);
        exp_t e;
        reset      = rst;
        load       = ld;
        load_value = lv;
        enable     = en;
        count_down = cd;
        model_step(rst, ld, lv, en, cd, e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_const(input string tag, input logic [26:0] obs, input logic [26:0] req);
        n_tests++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed {digits,ro,ex}=%07h expected %07h", tag, obs, req);
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        count_down = 1'b0;
        load       = 1'b0;
        load_value = '0;

        step(1, 0, 24'h000000, 0, 0, "reset");
        step(1, 0, 24'h000000, 1, 0, "reset_en");
        check_const("reset_const", {digits, rollover, expired, load_error}, {24'h000000, 3'b000});

        for (int i = 0; i < 61; i++) step(0, 0, 24'h000000, 1, 0, "up61");
        check_const("up61_const", {digits, rollover, expired, load_error}, {24'h000101, 3'b000});
        step(0, 0, 24'h000000, 0, 0, "hold");

        step(0, 1, 24'h235958, 0, 0, "ld_235958");
        step(0, 0, 24'h000000, 1, 0, "to_235959");
        check_const("at_235959", {digits, rollover, expired, load_error}, {24'h235959, 3'b000});
        step(0, 0, 24'h000000, 1, 0, "wrap");
        check_const("wrap_const", {digits, rollover, expired, load_error}, {24'h000000, 3'b100});
        step(0, 0, 24'h000000, 1, 0, "post_wrap");

        step(0, 1, 24'h000002, 0, 1, "ld_000002");
        step(0, 0, 24'h000000, 1, 1, "down_1");
        step(0, 0, 24'h000000, 1, 1, "down_0");
        check_const("expired_const", {digits, rollover, expired, load_error}, {24'h000000, 3'b010});
        step(0, 0, 24'h000000, 1, 1, "exp_hold");
        step(0, 0, 24'h000000, 0, 1, "exp_hold_noen");
        step(0, 1, 24'h240000, 1, 1, "exp_badload");
        step(0, 0, 24'h000000, 1, 0, "exp_exit");
        step(0, 0, 24'h000000, 1, 0, "after_exit");
        check_const("after_exit_const", {digits, rollover, expired, load_error}, {24'h000001, 3'b000});

        step(0, 1, 24'h000001, 0, 0, "ld_000001");
        step(0, 0, 24'h000000, 0, 1, "down_noen");
        step(0, 0, 24'h000000, 1, 1, "down_to_zero");

        step(0, 1, 24'h001000, 0, 1, "ld_001000");
        step(0, 0, 24'h000000, 1, 1, "borrow_chain");
        check_const("borrow_const", {digits, rollover, expired, load_error}, {24'h000959, 3'b000});
        step(0, 1, 24'h200000, 0, 1, "ld_200000");
        step(0, 0, 24'h000000, 1, 1, "hour_borrow");

        step(0, 1, 24'h240000, 0, 0, "bad_240000");
        step(0, 1, 24'h126000, 0, 0, "bad_126000");
        step(0, 1, 24'h095A00, 1, 0, "bad_095A00");
        check_const("bad_hold_const", {digits, rollover, expired, load_error}, {24'h195959, 3'b001});
        step(0, 1, 24'h195959, 0, 0, "ld_195959");
        step(0, 0, 24'h000000, 1, 0, "up_to_20");

        step(0, 1, 24'h123456, 1, 0, "ld_vs_count");
        check_const("ld_vs_count_const", {digits, rollover, expired, load_error}, {24'h123456, 3'b000});
        step(1, 1, 24'h123456, 1, 0, "rst_vs_load");
        check_const("rst_vs_load_const", {digits, rollover, expired, load_error}, {24'h000000, 3'b000});
        step(0, 0, 24'h000000, 1, 1, "zero_down_expire");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
